// File: rtl/shifter_controller_if.sv
// SPI link between the shifter controller (master) and the serial barrel
// shifter (slave). Only nss, mosi and miso are carried; both ends share the
// system clock, so there is no serial clock line.
interface Spi #(
   parameter int NssWidth = 1
);
   logic [NssWidth-1:0] nss;
   logic                mosi;
   logic                miso;

   modport MasterSpi (output nss, output mosi, input miso);
   modport SlaveSpi  (input nss, input mosi, output miso);
endinterface

// File: rtl/shifter_controller.sv
// Round-robin SPI master that shares the serial barrel shifter between
// several requesters: grant, send start bit + packet LSB first, wait for the
// slave's send marker on miso, collect the result LSB first, pulse done.
//
// Handshake: i_req is a level; the cycle o_grant pulses, the requester's
// packet is captured and the requester may drop i_req. o_done pulses once
// per accepted request with o_done_id/o_result/o_error valid in that cycle;
// those three hold their value until the next o_done.
module shifter_controller #(
   parameter int NumRequesters = 2,
   parameter int NssPosition   = 0,
   parameter int NssWidth      = 1,
   parameter int TimeoutCycles = 64,
   parameter int PacketBits    = 13,
   parameter int RegisterSize  = 8,
   localparam int IdWidth      = (NumRequesters > 1) ? $clog2(NumRequesters) : 1
) (
   input  logic                                 i_clock,
   input  logic                                 i_reset,
   input  logic [NumRequesters-1:0]             i_req,
   input  logic [NumRequesters*PacketBits-1:0]  i_packet,
   output logic [NumRequesters-1:0]             o_grant,
   output logic                                 o_busy,
   output logic                                 o_done,
   output logic [IdWidth-1:0]                   o_done_id,
   output logic [RegisterSize-1:0]              o_result,
   output logic                                 o_error,
   output logic [2:0]                           o_dbg_state,
   Spi.MasterSpi                                spi
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_TX    = 3'd2,
      S_WAIT  = 3'd3,
      S_RX    = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam int CntMaxA  = (PacketBits > RegisterSize) ? PacketBits : RegisterSize;
   localparam int CntMax   = (CntMaxA > TimeoutCycles) ? CntMaxA : TimeoutCycles;
   localparam int CntWidth = $clog2(CntMax + 1);
   localparam int RxIdxW   = $clog2(RegisterSize);

   localparam logic [CntWidth-1:0] TxLast   = CntWidth'(PacketBits - 1);
   localparam logic [CntWidth-1:0] RxLast   = CntWidth'(RegisterSize - 1);
   localparam logic [CntWidth-1:0] WaitLast = CntWidth'(TimeoutCycles - 1);
   localparam logic [IdWidth-1:0]  LastId   = IdWidth'(NumRequesters - 1);

   state_t                    r_state;
   state_t                    w_next_state;
   logic [CntWidth-1:0]       r_cnt;
   logic [PacketBits-1:0]     r_packet;
   logic [IdWidth-1:0]        r_id;
   logic [IdWidth-1:0]        r_rr;
   logic [RegisterSize-1:0]   r_rx;
   logic [RegisterSize-1:0]   r_result;
   logic [IdWidth-1:0]        r_done_id;
   logic                      r_error;

   logic                      w_any_req;
   logic                      w_found_hi;
   logic [IdWidth-1:0]        w_win_hi;
   logic [IdWidth-1:0]        w_win_lo;
   logic [IdWidth-1:0]        w_winner;
   logic [IdWidth-1:0]        w_rr_next;
   logic [PacketBits-1:0]     w_sel_packet;
   logic [RegisterSize-1:0]   w_rx_next;
   logic [NssWidth-1:0]       w_nss;

   // Round-robin pick: lowest asserted index at/after r_rr, else lowest overall.
   always_comb begin
      w_any_req    = 1'b0;
      w_found_hi   = 1'b0;
      w_win_hi     = '0;
      w_win_lo     = '0;
      w_sel_packet = '0;
      for (int j = NumRequesters - 1; j >= 0; j--) begin
         if (i_req[j]) begin
            w_any_req = 1'b1;
            w_win_lo  = j[IdWidth-1:0];
            if (j >= int'(r_rr)) begin
               w_found_hi = 1'b1;
               w_win_hi   = j[IdWidth-1:0];
            end
         end
      end
      w_winner  = w_found_hi ? w_win_hi : w_win_lo;
      w_rr_next = (w_winner == LastId) ? '0 : w_winner + 1'b1;
      for (int j = 0; j < NumRequesters; j++) begin
         if (w_winner == j[IdWidth-1:0]) w_sel_packet = i_packet[j*PacketBits +: PacketBits];
      end
   end

   // Result assembly: current miso lands at bit position rx_cnt.
   always_comb begin
      w_rx_next                         = r_rx;
      w_rx_next[r_cnt[RxIdxW-1:0]]      = spi.miso;
   end

   // State register.
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next_state;
   end

   // Next-state logic; miso is only looked at in WAIT (via w_rx_next in RX).
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next_state = S_START;
         S_START: w_next_state = S_TX;
         S_TX:    if (r_cnt == TxLast) w_next_state = S_WAIT;
         S_WAIT: begin
            if (spi.miso)                w_next_state = S_RX;
            else if (r_cnt == WaitLast)  w_next_state = S_DONE;
         end
         S_RX:    if (r_cnt == RxLast) w_next_state = S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Counters, packet shift register, arbitration pointer and result capture.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_cnt     <= '0;
         r_packet  <= '0;
         r_id      <= '0;
         r_rr      <= '0;
         r_rx      <= '0;
         r_result  <= '0;
         r_done_id <= '0;
         r_error   <= 1'b0;
      end else begin
         if (r_state == S_IDLE || w_next_state != r_state) r_cnt <= '0;
         else                                              r_cnt <= r_cnt + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_packet <= w_sel_packet;
                  r_id     <= w_winner;
                  r_rr     <= w_rr_next;
                  r_rx     <= '0;
               end
            end
            S_TX: r_packet <= r_packet >> 1;
            S_WAIT: begin
               if (w_next_state == S_DONE) begin
                  r_done_id <= r_id;
                  r_result  <= '0;
                  r_error   <= 1'b1;
               end
            end
            S_RX: begin
               r_rx <= w_rx_next;
               if (w_next_state == S_DONE) begin
                  r_done_id <= r_id;
                  r_result  <= w_rx_next;
                  r_error   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs decoded from state; nss is low only while a transaction is on the wire.
   always_comb begin
      w_nss   = '1;
      o_grant = '0;
      spi.mosi = 1'b0;
      if (r_state == S_START || r_state == S_TX || r_state == S_WAIT || r_state == S_RX)
         w_nss[NssPosition] = 1'b0;
      if (r_state == S_START) spi.mosi = 1'b1;
      if (r_state == S_TX)    spi.mosi = r_packet[0];
      if (r_state == S_IDLE && w_any_req) begin
         for (int j = 0; j < NumRequesters; j++) begin
            o_grant[j] = (w_winner == j[IdWidth-1:0]);
         end
      end
      spi.nss     = w_nss;
      o_busy      = (r_state != S_IDLE);
      o_done      = (r_state == S_DONE);
      o_done_id   = r_done_id;
      o_result    = r_result;
      o_error     = r_error;
      o_dbg_state = r_state;
   end

endmodule

// File: tb/tb_shifter_controller.sv
// Bench for shifter_controller: behavioural shifter slave on the SPI link,
// vector table of directed transactions, hand-written reset/fairness
// sequences, and randomized requests checked against a round-robin model.
module tb_shifter_controller;
  localparam int N      = 2;
  localparam int P      = 13;
  localparam int R      = 8;
  localparam int T      = 64;
  localparam int LAT    = P + R + 4;
  localparam int LAT_TO = P + 2 + T;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N*P-1:0]   pkts;
  logic [N-1:0]     grant;
  logic             busy, done, err;
  logic [0:0]       done_id;
  logic [R-1:0]     result;
  logic [2:0]       dbg_state;

  Spi #(.NssWidth(1)) spi_bus ();

  shifter_controller #(
    .NumRequesters(N), .NssPosition(0), .NssWidth(1), .TimeoutCycles(T),
    .PacketBits(P), .RegisterSize(R)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_packet(pkts),
    .o_grant(grant), .o_busy(busy), .o_done(done), .o_done_id(done_id),
    .o_result(result), .o_error(err), .o_dbg_state(dbg_state), .spi(spi_bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // packet = {shift_amount[2:0], op[7:0], op_code[1:0]}; op_code 0=SHL, 1=SHR
  function automatic logic [P-1:0] pk(input int sh, input int op, input int code);
    logic [2:0] s; logic [7:0] o; logic [1:0] c;
    s = sh[2:0]; o = op[7:0]; c = code[1:0];
    return {s, o, c};
  endfunction

  function automatic logic [R-1:0] shift_model(input logic [P-1:0] p);
    int op, sh, v;
    op = int'(p[9:2]);
    sh = int'(p[12:10]);
    case (p[1:0])
      2'd0:    v = (op * (1 << sh)) % 256;
      2'd1:    v = op / (1 << sh);
      default: v = 0;
    endcase
    return v[R-1:0];
  endfunction

  // behavioural shifter slave: start bit, P packet bits, OPERATE, SEND marker, R result bits
  int          s_cyc = 0;
  logic        s_start;
  logic [P-1:0] s_pkt;
  logic [R-1:0] s_res;
  logic        s_mute = 1'b0;

  always @(posedge clk) begin
    if (spi_bus.nss[0] !== 1'b0) begin
      s_cyc = 0;
      spi_bus.miso <= 1'b0;
    end else begin
      if (s_cyc == 0) s_start = spi_bus.mosi;
      else if (s_cyc <= P) s_pkt[s_cyc-1] = spi_bus.mosi;
      s_cyc++;
      if (s_cyc == P + 1) s_res = shift_model(s_pkt);
      if (s_mute) spi_bus.miso <= 1'b0;
      else if (s_cyc == P + 2) spi_bus.miso <= 1'b1;
      else if (s_cyc >= P + 3 && s_cyc < P + 3 + R) spi_bus.miso <= s_res[s_cyc-P-3];
      else spi_bus.miso <= 1'b0;
    end
  end

  // round-robin reference: first asserted requester at or after the pointer
  int model_rr = 0;
  function automatic int pick(input logic [N-1:0] mask);
    int w;
    w = -1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[(model_rr + i) % N]) w = (model_rr + i) % N;
    end
    model_rr = (w + 1) % N;
    return w;
  endfunction

  // driver: one full transaction from request to done
  task automatic run_txn(input logic [N-1:0] mask, input logic [P-1:0] p0, input logic [P-1:0] p1,
                         input logic mute, input logic hold, input int exp_id,
                         input logic [R-1:0] exp_res, input logic exp_err);
    int cycles;
    logic [P-1:0] exp_pkt;
    exp_pkt = (exp_id == 0) ? p0 : p1;
    @(negedge clk);
    req = mask; pkts = {p1, p0}; s_mute = mute;
    #1;
    check("grant", 32'(grant), 32'(1 << exp_id));
    check("busy_idle", 32'(busy), 0);
    check("nss_before_start", 32'(spi_bus.nss), 1);
    @(negedge clk);
    cycles = 1;
    check("grant_pulse", 32'(grant), 0);
    check("busy_start", 32'(busy), 1);
    check("nss_start", 32'(spi_bus.nss), 0);
    check("mosi_start", 32'(spi_bus.mosi), 1);
    if (!hold) begin
      req = '0;
      pkts = {$urandom, $urandom};
    end
    while (done !== 1'b1 && cycles < LAT_TO + 10) begin
      @(negedge clk);
      cycles++;
    end
    check("done_latency", cycles, mute ? LAT_TO : LAT);
    check("done_id", 32'(done_id), exp_id);
    check("result", 32'(result), 32'(exp_res));
    check("error", 32'(err), 32'(exp_err));
    check("nss_done", 32'(spi_bus.nss), 1);
    check("mosi_trace", {18'd0, s_start, s_pkt}, {18'd0, 1'b1, exp_pkt});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_rr = 0;
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [P-1:0] p0;
    logic [P-1:0] p1;
    logic         mute;
    int           exp_id;
    logic [R-1:0] exp_res;
    logic         exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, cnt_done;
    logic [N-1:0] m;
    logic [P-1:0] a, b;
    logic mu;

    rst = 1'b1; req = '0; pkts = '0;
    vecs[0] = '{2'b01, pk(2, 8'h0F, 0), pk(0, 0, 0),       1'b0, 0, 8'h3C, 1'b0};
    vecs[1] = '{2'b10, pk(0, 0, 0),       pk(4, 8'hF0, 1), 1'b0, 1, 8'h0F, 1'b0};
    vecs[2] = '{2'b01, pk(0, 8'hFF, 3),   pk(0, 0, 0),     1'b0, 0, 8'h00, 1'b0};
    vecs[3] = '{2'b01, pk(0, 8'hA5, 0),   pk(0, 0, 0),     1'b0, 0, 8'hA5, 1'b0};
    vecs[4] = '{2'b01, pk(3, 8'h11, 0),   pk(0, 0, 0),     1'b1, 0, 8'h00, 1'b1};
    vecs[5] = '{2'b11, pk(1, 8'h01, 0),   pk(1, 8'h81, 0), 1'b0, 1, 8'h02, 1'b0};
    vecs[6] = '{2'b11, pk(7, 8'h80, 1),   pk(2, 8'h03, 0), 1'b0, 0, 8'h01, 1'b0};

    // reset state
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    check("rst_error", 32'(err), 0);
    check("rst_done_id", 32'(done_id), 0);
    check("rst_nss", 32'(spi_bus.nss), 1);
    check("rst_mosi", 32'(spi_bus.mosi), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 7; i++) begin
      id = pick(vecs[i].mask);
      run_txn(vecs[i].mask, vecs[i].p0, vecs[i].p1, vecs[i].mute, 1'b0,
              vecs[i].exp_id, vecs[i].exp_res, vecs[i].exp_err);
    end

    // fairness: both requesters held for three back-to-back transactions
    do_reset();
    a = pk(1, 8'h33, 0); b = pk(2, 8'hC0, 1);
    run_txn(2'b11, a, b, 1'b0, 1'b1, 0, 8'h66, 1'b0);
    run_txn(2'b11, a, b, 1'b0, 1'b1, 1, 8'h30, 1'b0);
    run_txn(2'b11, a, b, 1'b0, 1'b0, 0, 8'h66, 1'b0);
    model_rr = 1;

    // reset during TX bit 3 aborts silently
    do_reset();
    @(negedge clk);
    req = 2'b01; pkts = {pk(0, 0, 0), pk(1, 8'h0F, 0)};
    repeat (5) @(negedge clk);
    req = '0;
    check("tx_bit3_state", 32'(dbg_state), 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort_nss", 32'(spi_bus.nss), 1);
    check("abort_mosi", 32'(spi_bus.mosi), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    rst = 1'b0;
    model_rr = 0;
    cnt_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1) cnt_done++;
    end
    check("abort_no_done", cnt_done, 0);
    id = pick(2'b01);
    run_txn(2'b01, pk(1, 8'h0F, 0), pk(0, 0, 0), 1'b0, 1'b0, 0, 8'h1E, 1'b0);

    // randomized requests against the round-robin / shifter reference
    for (int i = 0; i < 20; i++) begin
      m  = N'($urandom_range(1, 3));
      a  = P'($urandom);
      b  = P'($urandom);
      mu = ($urandom_range(0, 7) == 0);
      id = pick(m);
      run_txn(m, a, b, mu, 1'b0, id,
              mu ? 8'h00 : shift_model((id == 0) ? a : b), mu);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
